// File: rtl/drenador_pkg.sv
// ============================================================================
//  drenador_pkg
//  Shared types, default widths and helpers for the store-buffer drainer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package drenador_pkg;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned WIDTH_DEF       = ADDR_W_DEF + DATA_W_DEF;
    localparam int unsigned TIMEOUT_DEF     = 16;
    localparam int unsigned MAX_RETRIES_DEF = 3;
    localparam int unsigned CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        POP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } entrada_t;

    // Bits needed to hold the value max_val (never less than one).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_timeout.sv
// ============================================================================
//  contador_timeout
//  Up-counter with synchronous clear and enable; tc flags the value MAX_VAL.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module contador_timeout
    import drenador_pkg::*;
#(
    parameter int unsigned MAX_VAL = TIMEOUT_DEF - 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = cnt_width(MAX_VAL);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(MAX_VAL));

endmodule

`default_nettype wire

// File: rtl/drenador_buffer.sv
// ============================================================================
//  drenador_buffer
//  Drains the store-buffer head to memory (req/gnt/done) with timeout/retry.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module drenador_buffer
    import drenador_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int unsigned MAX_RETRIES = MAX_RETRIES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              enable_i,
    input  logic [WIDTH-1:0]  dato_i,
    input  logic              vacia_i,
    output logic              delecion_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_gnt_i,
    input  logic              mem_done_i,
    output logic              idle_o,
    output logic              error_o,
    output logic [CNT_W-1:0]  drenados_o
);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] entry;
    logic [CNT_W-1:0] drained;
    logic             error;
    logic             start;
    logic             retry;
    logic             drop;
    logic             to_tc;
    logic             rt_tc;

    // Done wins over an expiring timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        retry     = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i && !vacia_i) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_done_i) begin
                    state_nxt = POP;
                end else if (to_tc) begin
                    if (rt_tc) begin
                        drop      = 1'b1;
                        state_nxt = POP;
                    end else begin
                        retry     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            POP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            entry   <= '0;
            error   <= 1'b0;
            drained <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                entry <= dato_i;
            end
            if (drop) begin
                error <= 1'b1;
            end
            if (state == POP) begin
                drained <= drained + 1'b1;
            end
        end
    end

    contador_timeout #(
        .MAX_VAL (TIMEOUT - 1)
    ) u_timeout (
        .clk  (clk_i),
        .rstn (rstn_i),
        .clr  (state != WAIT),
        .en   (state == WAIT),
        .tc   (to_tc)
    );

    contador_timeout #(
        .MAX_VAL (MAX_RETRIES)
    ) u_retries (
        .clk  (clk_i),
        .rstn (rstn_i),
        .clr  (start),
        .en   (retry),
        .tc   (rt_tc)
    );

    generate
        if (ADDR_W == ADDR_W_DEF && DATA_W == DATA_W_DEF) begin : g_struct
            entrada_t ent;
            assign ent        = entrada_t'(entry);
            assign mem_addr_o = ent.addr;
            assign mem_data_o = ent.data;
        end else begin : g_slice
            assign mem_addr_o = entry[WIDTH-1:DATA_W];
            assign mem_data_o = entry[DATA_W-1:0];
        end
    endgenerate

    assign mem_req_o  = (state == REQ);
    assign delecion_o = (state == POP);
    assign idle_o     = (state == IDLE);
    assign error_o    = error;
    assign drenados_o = drained;

endmodule

`default_nettype wire

// File: tb/tb_drenador_buffer.sv
// ============================================================================
//  tb_drenador_buffer
//  Self-checking bench: buffer/memory models plus directed drain scenarios.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_drenador_buffer;

    localparam int unsigned TIMEOUT     = 16;
    localparam int unsigned MAX_RETRIES = 3;
    localparam int unsigned CNT_W       = 16;

    logic        clk        = 1'b0;
    logic        rstn_i     = 1'b0;
    logic        enable_i   = 1'b0;
    logic [63:0] dato_i     = '0;
    logic        vacia_i    = 1'b1;
    logic        mem_gnt_i  = 1'b0;
    logic        mem_done_i = 1'b0;
    logic        delecion_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        idle_o;
    logic        error_o;
    logic [15:0] drenados_o;

    drenador_buffer #(
        .WIDTH(64), .ADDR_W(32), .DATA_W(32),
        .TIMEOUT(TIMEOUT), .MAX_RETRIES(MAX_RETRIES), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .enable_i(enable_i), .dato_i(dato_i),
        .vacia_i(vacia_i), .delecion_o(delecion_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_gnt_i(mem_gnt_i),
        .mem_done_i(mem_done_i), .idle_o(idle_o), .error_o(error_o),
        .drenados_o(drenados_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Buffer contents (head at index 0) and observation logs.
    logic [63:0] q[$];
    logic [63:0] req_log[$];
    int          req_cyc_log[$];
    int          pop_cyc[$];

    // Expected-behaviour model state.
    int cyc = 0, model_pops = 0, tot_reqs = 0, attempts = 0, gnt_cyc = 0;
    bit model_err = 0, done_given = 0, rst_seen = 0, prev_req = 0, prev_del = 0;

    // Memory responder knobs and state.
    int gnt_dly = 0, done_dly = 1, skip_left = 0;
    bit done_in_req = 0;
    int req_cyc = 0, wcnt = 0;
    bit granted = 0, this_skip = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor, buffer model, memory responder and per-cycle comparison.
    always @(negedge clk) begin
        cyc++;
        if (rst_seen) begin
            model_pops = 0; model_err = 0; attempts = 0; done_given = 0;
            tot_reqs = 0; granted = 0; req_cyc = 0; prev_req = 0; prev_del = 0;
            req_log.delete(); req_cyc_log.delete(); pop_cyc.delete();
        end
        rst_seen = !rstn_i;

        check("one_state", 64'($countones({idle_o, mem_req_o, delecion_o}) <= 1), 64'd1);
        check("drenados", 64'(drenados_o), 64'(CNT_W'(model_pops)));

        if (mem_req_o) begin
            if (q.size() == 0) check("req_nonempty", 64'd0, 64'd1);
            else check("req_entry", {mem_addr_o, mem_data_o}, q[0]);
            if (!prev_req) begin
                tot_reqs++;
                attempts++;
                req_log.push_back({mem_addr_o, mem_data_o});
                req_cyc_log.push_back(cyc);
                if (attempts > 1) check("retry_gap", 64'(cyc - gnt_cyc), 64'(TIMEOUT + 1));
                check("attempt_limit", 64'(attempts > int'(MAX_RETRIES) + 1), 64'd0);
            end
        end

        if (delecion_o) begin
            check("pop_nonempty", 64'(q.size() > 0), 64'd1);
            check("pop_single", 64'(prev_del), 64'd0);
            if (!done_given) begin
                model_err = 1;
                check("drop_attempts", 64'(attempts), 64'(MAX_RETRIES + 1));
                check("drop_gap", 64'(cyc - gnt_cyc), 64'(TIMEOUT + 1));
            end
            pop_cyc.push_back(cyc);
            if (q.size() > 0) void'(q.pop_front());
            model_pops++;
            attempts   = 0;
            done_given = 0;
        end
        check("error", 64'(error_o), 64'(model_err));

        vacia_i = (q.size() == 0);
        dato_i  = (q.size() > 0) ? q[0] : 64'h0;

        mem_gnt_i  = 1'b0;
        mem_done_i = 1'b0;
        if (mem_req_o) begin
            granted = 0;
            req_cyc++;
            if (done_in_req && req_cyc == 1) mem_done_i = 1'b1;
            if (req_cyc > gnt_dly) begin
                mem_gnt_i = 1'b1;
                granted   = 1;
                wcnt      = 0;
                gnt_cyc   = cyc;
                this_skip = (skip_left > 0);
                if (this_skip) skip_left--;
            end
        end else begin
            req_cyc = 0;
            if (granted) begin
                wcnt++;
                if (!this_skip && wcnt >= done_dly) begin
                    mem_done_i = 1'b1;
                    done_given = 1;
                    granted    = 0;
                end
            end
        end
        prev_req = mem_req_o;
        prev_del = delecion_o;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(); rstn_i = 1'b0;
        step(); rstn_i = 1'b1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string nm);
        int k = 0;
        while (model_pops < n && k < budget) begin
            tick();
            k++;
        end
        check(nm, 64'(model_pops >= n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] exp_e;
        int          k;

        // Reset state.
        tick();
        check("rst_flags", {60'd0, mem_req_o, delecion_o, idle_o, error_o}, 64'h2);
        check("rst_cnt", 64'(drenados_o), 64'd0);
        check("rst_addr", {mem_addr_o, mem_data_o}, 64'd0);
        step(); rstn_i = 1'b1;

        // Single write: gnt 2 cycles after req, done 3 cycles after gnt.
        gnt_dly = 2; done_dly = 3;
        step(); q.push_back({32'h0000_1000, 32'hDEAD_BEEF}); enable_i = 1'b1;
        wait_pops(1, 60, "t1_pop");
        repeat (3) tick();
        check("t1_entry", (req_log.size() > 0) ? req_log[0] : 64'hX, 64'h0000_1000_DEAD_BEEF);
        check("t1_latency", (pop_cyc.size() > 0 && req_cyc_log.size() > 0) ?
              64'(pop_cyc[0] - req_cyc_log[0]) : 64'hX, 64'd6);
        check("t1_reqs", 64'(tot_reqs), 64'd1);
        check("t1_cnt", 64'(drenados_o), 64'd1);
        check("t1_idle", 64'(idle_o), 64'd1);

        // Burst drain of 8 entries with immediate gnt/done.
        do_reset();
        gnt_dly = 0; done_dly = 1;
        step();
        for (int i = 0; i < 8; i++) q.push_back({32'h2000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i)});
        wait_pops(8, 100, "t2_pops");
        repeat (20) tick();
        check("t2_no_extra", 64'(model_pops), 64'd8);
        check("t2_cnt", 64'(drenados_o), 64'd8);
        check("t2_empty", 64'(vacia_i), 64'd1);
        for (int i = 1; i < 8; i++)
            check("t2_gap", (pop_cyc.size() == 8) ? 64'(pop_cyc[i] - pop_cyc[i-1]) : 64'hX, 64'd4);
        for (int i = 0; i < 8; i++) begin
            exp_e = {32'h2000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i)};
            check("t2_order", (req_log.size() == 8) ? req_log[i] : 64'hX, exp_e);
        end

        // Retry: first attempt unanswered, second completes.
        do_reset();
        skip_left = 1;
        step(); q.push_back({32'h0000_3000, 32'h1234_5678});
        wait_pops(1, 100, "t3_pop");
        repeat (3) tick();
        check("t3_reqs", 64'(tot_reqs), 64'd2);
        check("t3_same", (req_log.size() == 2) ? req_log[1] : 64'hX, 64'h0000_3000_1234_5678);
        check("t3_err", 64'(error_o), 64'd0);
        check("t3_cnt", 64'(drenados_o), 64'd1);

        // Drop: done never returned, then error stays sticky.
        do_reset();
        skip_left = 100;
        step(); q.push_back({32'h0000_4000, 32'hCAFE_F00D});
        wait_pops(1, 200, "t4_pop");
        repeat (2) tick();
        check("t4_reqs", 64'(tot_reqs), 64'd4);
        check("t4_err", 64'(error_o), 64'd1);
        check("t4_cnt", 64'(drenados_o), 64'd1);
        skip_left = 0;
        step(); q.push_back({32'h0000_4100, 32'h0000_0001});
        wait_pops(2, 60, "t4_pop2");
        repeat (2) tick();
        check("t4_sticky", 64'(error_o), 64'd1);
        check("t4_cnt2", 64'(drenados_o), 64'd2);

        // Reset mid-WAIT keeps the entry upstream; it is drained again.
        do_reset();
        tick();
        check("t5_err_clr", 64'(error_o), 64'd0);
        skip_left = 100;
        step(); q.push_back({32'h0000_5000, 32'h55AA_55AA});
        k = 0;
        while (!(tot_reqs > 0 && !mem_req_o) && k < 30) begin tick(); k++; end
        repeat (3) tick();
        check("t5_in_wait", {61'd0, idle_o, mem_req_o, delecion_o}, 64'd0);
        skip_left = 0;
        step(); rstn_i = 1'b0;
        step(); rstn_i = 1'b1;
        tick();
        check("t5_rst_flags", {60'd0, mem_req_o, delecion_o, idle_o, error_o}, 64'h2);
        check("t5_rst_cnt", 64'(drenados_o), 64'd0);
        check("t5_rst_addr", {mem_addr_o, mem_data_o}, 64'd0);
        check("t5_kept", 64'(q.size()), 64'd1);
        wait_pops(1, 60, "t5_redrain");
        repeat (2) tick();
        check("t5_cnt", 64'(drenados_o), 64'd1);
        check("t5_entry", (req_log.size() > 0) ? req_log[req_log.size()-1] : 64'hX,
              64'h0000_5000_55AA_55AA);

        // Enable gating, done ignored in REQ, enable drop mid-drain.
        enable_i = 1'b0;
        do_reset();
        gnt_dly = 2; done_dly = 1; done_in_req = 1;
        step();
        q.push_back({32'h0000_6000, 32'h6666_0000});
        q.push_back({32'h0000_6004, 32'h6666_0001});
        repeat (10) tick();
        check("t6_no_req", 64'(tot_reqs), 64'd0);
        check("t6_idle", 64'(idle_o), 64'd1);
        step(); enable_i = 1'b1;
        tick();
        check("t6_req_before", 64'(mem_req_o), 64'd0);
        tick();
        check("t6_req_after", 64'(mem_req_o), 64'd1);
        tick();
        check("t6_done_ignored", {62'd0, mem_req_o, delecion_o}, 64'h2);
        step(); enable_i = 1'b0;
        wait_pops(1, 40, "t6_pop1");
        repeat (10) tick();
        check("t6_hold_pops", 64'(model_pops), 64'd1);
        check("t6_hold_reqs", 64'(tot_reqs), 64'd1);
        check("t6_hold_idle", 64'(idle_o), 64'd1);
        step(); enable_i = 1'b1;
        wait_pops(2, 40, "t6_pop2");
        repeat (2) tick();
        check("t6_cnt", 64'(drenados_o), 64'd2);
        check("t6_err", 64'(error_o), 64'd0);
        done_in_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
